// File: rtl/qspi_flash_pkg.sv
// Shared definitions for the QSPI NOR flash model: opcodes, FSM states,
// status-register layout and the JEDEC ID byte selector.
package qspi_flash_pkg;

    localparam logic [7:0] OP_NONE      = 8'h00;
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_QUAD_READ = 8'h6B;
    localparam logic [7:0] OP_PP        = 8'h02;
    localparam logic [7:0] OP_SE        = 8'h20;
    localparam logic [7:0] OP_WREN      = 8'h06;
    localparam logic [7:0] OP_WRDI      = 8'h04;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_RDID      = 8'h9F;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RD_DATA,
        ST_WR_DATA, ST_STATUS, ST_ID, ST_IGNORE
    } state_e;

    typedef enum logic [1:0] {
        ENG_IDLE, ENG_PROG, ENG_ERASE
    } eng_e;

    // ID bytes go out MSB first; anything past the third byte reads as 0xFF.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = id[23:16];
            2'd1:    id_byte = id[15:8];
            2'd2:    id_byte = id[7:0];
            default: id_byte = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/qspi_flash_model_spi_edge_sync.sv
// Brings sck and csn into the clk domain and produces single-clk edge pulses.
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic csn,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic csn_lvl
);

    logic [2:0] sck_sync_r;
    logic [2:0] csn_sync_r;

    // Two synchroniser stages plus one delay stage used for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync_r <= 3'b000;
            csn_sync_r <= 3'b111;
        end else begin
            sck_sync_r <= {sck_sync_r[1:0], sck};
            csn_sync_r <= {csn_sync_r[1:0], csn};
        end
    end

    assign sck_rise = sck_sync_r[1] & ~sck_sync_r[2];
    assign sck_fall = ~sck_sync_r[1] & sck_sync_r[2];
    assign cs_fall  = ~csn_sync_r[1] & csn_sync_r[2];
    assign cs_rise  = csn_sync_r[1] & ~csn_sync_r[2];
    assign csn_lvl  = csn_sync_r[1];

endmodule

// File: rtl/qspi_flash_model.sv
// Clock-sampled serial NOR flash model with single/quad reads, page program,
// 4 KB sector erase, status/ID reads and a backdoor preload port.
module qspi_flash_model
    import qspi_flash_pkg::*;
#(
    parameter int          MEM_AW       = 16,
    parameter int          ADDR_BYTES   = 3,
    parameter int          DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'h010220,
    parameter int          PROG_CYCLES  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              csn,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    input  logic              pl_we,
    input  logic [MEM_AW-1:0] pl_addr,
    input  logic [7:0]        pl_data
);

    localparam logic [MEM_AW-1:0] SECT_MASK = MEM_AW'(12'hFFF);

    reg [7:0] mem [0:2**MEM_AW-1];

    logic sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s, csn_lvl_s;
    state_e state_r, state_nx_s, dec_state_s;
    eng_e eng_state_r;
    logic [15:0] cnt_r;
    logic [31:0] sr_r, addr_full_s, eng_cnt_r;
    logic [MEM_AW-1:0] addr_r, eng_addr_r, mem_wa_s;
    logic [7:0] op_r, dec_op_s, cmd_byte_s, status_s, cur_byte_s, tx_src_s, tx_r, mem_wd_s;
    logic [2:0] phase_r;
    logic [1:0] id_idx_r;
    logic [3:0] io_out_r, io_oe_r;
    logic prog_any_r, erase_arm_r, wel_r, wip_s, mem_we_s;
    logic addr_last_s, quad_s, last_slot_s, unused_s;

    spi_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .csn      (csn),
        .sck_rise (sck_rise_s),
        .sck_fall (sck_fall_s),
        .cs_fall  (cs_fall_s),
        .cs_rise  (cs_rise_s),
        .csn_lvl  (csn_lvl_s)
    );

    assign cmd_byte_s  = {sr_r[6:0], io_in[0]};
    assign addr_full_s = {sr_r[30:0], io_in[0]};
    assign addr_last_s = (cnt_r == 16'(ADDR_BYTES * 8 - 1));
    assign wip_s       = (eng_state_r != ENG_IDLE);
    assign quad_s      = (state_r == ST_RD_DATA) && (op_r == OP_QUAD_READ);
    assign last_slot_s = quad_s ? (phase_r == 3'd1) : (phase_r == 3'd7);
    assign tx_src_s    = (phase_r == 3'd0) ? cur_byte_s : tx_r;
    assign io_out      = io_out_r;
    assign io_oe       = io_oe_r;
    assign unused_s    = ^{io_in[3:1], sr_r[31], addr_full_s[31:MEM_AW]};

    // Status byte assembly
    always_comb begin
        status_s         = 8'h00;
        status_s[SR_WIP] = wip_s;
        status_s[SR_WEL] = wel_r;
    end

    // Opcode decode; a busy part only answers status reads
    always_comb begin
        dec_state_s = ST_IGNORE;
        dec_op_s    = OP_NONE;
        if (wip_s) begin
            if (cmd_byte_s == OP_RDSR) begin
                dec_state_s = ST_STATUS;
                dec_op_s    = OP_RDSR;
            end else begin
                dec_state_s = ST_IGNORE;
                dec_op_s    = OP_NONE;
            end
        end else begin
            case (cmd_byte_s)
                OP_READ, OP_FAST_READ, OP_QUAD_READ: begin
                    dec_state_s = ST_ADDR;
                    dec_op_s    = cmd_byte_s;
                end
                OP_PP, OP_SE: begin
                    dec_state_s = wel_r ? ST_ADDR : ST_IGNORE;
                    dec_op_s    = wel_r ? cmd_byte_s : OP_NONE;
                end
                OP_WREN, OP_WRDI: begin
                    dec_state_s = ST_IGNORE;
                    dec_op_s    = cmd_byte_s;
                end
                OP_RDSR: begin
                    dec_state_s = ST_STATUS;
                    dec_op_s    = OP_RDSR;
                end
                OP_RDID: begin
                    dec_state_s = ST_ID;
                    dec_op_s    = OP_RDID;
                end
                default: begin
                    dec_state_s = ST_IGNORE;
                    dec_op_s    = OP_NONE;
                end
            endcase
        end
    end

    // Next-state logic; cs_rise outranks a coincident sck_rise
    always_comb begin
        state_nx_s = state_r;
        if (cs_rise_s) begin
            state_nx_s = ST_IDLE;
        end else if (cs_fall_s && (state_r == ST_IDLE)) begin
            state_nx_s = ST_CMD;
        end else if (sck_rise_s) begin
            case (state_r)
                ST_CMD: begin
                    if (cnt_r[2:0] == 3'd7) state_nx_s = dec_state_s;
                    else                    state_nx_s = state_r;
                end
                ST_ADDR: begin
                    if (addr_last_s) begin
                        case (op_r)
                            OP_READ:                    state_nx_s = ST_RD_DATA;
                            OP_FAST_READ, OP_QUAD_READ: state_nx_s = (DUMMY_CYCLES == 0) ? ST_RD_DATA : ST_DUMMY;
                            OP_PP:                      state_nx_s = ST_WR_DATA;
                            default:                    state_nx_s = ST_IGNORE;
                        endcase
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_DUMMY: begin
                    if (cnt_r == 16'(DUMMY_CYCLES - 1)) state_nx_s = ST_RD_DATA;
                    else                                state_nx_s = state_r;
                end
                default: state_nx_s = state_r;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= state_nx_s;
    end

    // Byte currently being shifted out
    always_comb begin
        cur_byte_s = 8'h00;
        case (state_r)
            ST_RD_DATA: cur_byte_s = mem[addr_r];
            ST_STATUS:  cur_byte_s = status_s;
            ST_ID:      cur_byte_s = id_byte(JEDEC_ID, id_idx_r);
            default:    cur_byte_s = 8'h00;
        endcase
    end

    // Shift-in, address/counter tracking and pad drive on sck edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 16'd0;  sr_r <= 32'd0;  addr_r <= '0;  op_r <= OP_NONE;
            prog_any_r <= 1'b0;  erase_arm_r <= 1'b0;  tx_r <= 8'h00;
            phase_r <= 3'd0;  id_idx_r <= 2'd0;  io_out_r <= 4'h0;  io_oe_r <= 4'h0;
        end else if (cs_rise_s) begin
            io_out_r <= 4'h0;  io_oe_r <= 4'h0;  cnt_r <= 16'd0;  phase_r <= 3'd0;
        end else if (cs_fall_s && (state_r == ST_IDLE)) begin
            cnt_r <= 16'd0;  op_r <= OP_NONE;  prog_any_r <= 1'b0;
            erase_arm_r <= 1'b0;  phase_r <= 3'd0;  id_idx_r <= 2'd0;
        end else if (sck_rise_s) begin
            case (state_r)
                ST_CMD: begin
                    sr_r <= addr_full_s;
                    if (cnt_r[2:0] == 3'd7) begin
                        cnt_r <= 16'd0;
                        op_r  <= dec_op_s;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_ADDR: begin
                    sr_r <= addr_full_s;
                    if (addr_last_s) begin
                        cnt_r       <= 16'd0;
                        addr_r      <= addr_full_s[MEM_AW-1:0];
                        erase_arm_r <= (op_r == OP_SE);
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_DUMMY: cnt_r <= cnt_r + 16'd1;
                ST_WR_DATA: begin
                    sr_r <= addr_full_s;
                    if (cnt_r[2:0] == 3'd7) begin
                        cnt_r       <= 16'd0;
                        addr_r[7:0] <= addr_r[7:0] + 8'd1;
                        prog_any_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end else if (sck_fall_s) begin
            case (state_r)
                ST_RD_DATA, ST_STATUS, ST_ID: begin
                    if (quad_s) begin
                        io_out_r <= tx_src_s[7:4];
                        io_oe_r  <= 4'b1111;
                        tx_r     <= {tx_src_s[3:0], 4'h0};
                    end else begin
                        io_out_r <= {2'b00, tx_src_s[7], 1'b0};
                        io_oe_r  <= 4'b0010;
                        tx_r     <= {tx_src_s[6:0], 1'b0};
                    end
                    if (last_slot_s) begin
                        phase_r <= 3'd0;
                        if (state_r == ST_RD_DATA)                   addr_r   <= addr_r + MEM_AW'(1);
                        else if ((state_r == ST_ID) && (id_idx_r != 2'd3)) id_idx_r <= id_idx_r + 2'd1;
                        else                                          id_idx_r <= id_idx_r;
                    end else begin
                        phase_r <= phase_r + 3'd1;
                    end
                end
                default: begin
                    io_out_r <= 4'h0;
                    io_oe_r  <= 4'h0;
                end
            endcase
        end
    end

    // Program/erase engine and write-enable latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_state_r <= ENG_IDLE;  eng_cnt_r <= 32'd0;  eng_addr_r <= '0;  wel_r <= 1'b0;
        end else if (eng_state_r == ENG_ERASE) begin
            if (eng_cnt_r[11:0] == 12'hFFF) begin
                eng_state_r <= ENG_IDLE;
                eng_cnt_r   <= 32'd0;
                wel_r       <= 1'b0;
            end else begin
                eng_cnt_r <= eng_cnt_r + 32'd1;
            end
        end else if (eng_state_r == ENG_PROG) begin
            if (eng_cnt_r == 32'd0) begin
                eng_state_r <= ENG_IDLE;
                wel_r       <= 1'b0;
            end else begin
                eng_cnt_r <= eng_cnt_r - 32'd1;
            end
        end else if (cs_rise_s) begin
            case (op_r)
                OP_WREN: wel_r <= 1'b1;
                OP_WRDI: wel_r <= 1'b0;
                OP_PP: begin
                    if (prog_any_r) begin
                        eng_state_r <= ENG_PROG;
                        eng_cnt_r   <= 32'(PROG_CYCLES - 1);
                    end
                end
                OP_SE: begin
                    if (erase_arm_r) begin
                        eng_state_r <= ENG_ERASE;
                        eng_cnt_r   <= 32'd0;
                        eng_addr_r  <= addr_r & ~SECT_MASK;
                    end
                end
                default: wel_r <= wel_r;
            endcase
        end
    end

    // Single array write port: erase, then program commit, then backdoor
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = '0;
        mem_wd_s = 8'h00;
        if (eng_state_r == ENG_ERASE) begin
            mem_we_s = 1'b1;
            mem_wa_s = eng_addr_r | MEM_AW'(eng_cnt_r[11:0]);
            mem_wd_s = 8'hFF;
        end else if ((state_r == ST_WR_DATA) && sck_rise_s && !cs_rise_s && (cnt_r[2:0] == 3'd7)) begin
            mem_we_s = 1'b1;
            mem_wa_s = addr_r;
            mem_wd_s = mem[addr_r] & cmd_byte_s;
        end else if (pl_we && csn_lvl_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = pl_addr;
            mem_wd_s = pl_data;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Array storage, deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (mem_we_s) mem[mem_wa_s] <= mem_wd_s;
    end

endmodule

// File: tb/tb_qspi_flash_model.sv
// Directed bench for qspi_flash_model: reads, quad read, program, erase,
// status, ID and mid-transaction reset, all against hand-computed values.
module tb_qspi_flash_model;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sck = 1'b0;
    logic        csn = 1'b1;
    logic [3:0]  io_in = 4'h0;
    logic [3:0]  io_out, io_oe;
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = 16'h0000;
    logic [7:0]  pl_data = 8'h00;

    int checks = 0;
    int failures = 0;
    logic [7:0] rx;
    logic [3:0] oe_or, oe_and;

    qspi_flash_model #(
        .MEM_AW(16), .ADDR_BYTES(3), .DUMMY_CYCLES(8),
        .JEDEC_ID(24'h010220), .PROG_CYCLES(400)
    ) dut (
        .clk(clk), .rst(rst), .sck(sck), .csn(csn),
        .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
        .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_addr = a; pl_data = d; pl_we = 1'b1;
        wait_clk(1);
        pl_we = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, input bit quad);
        oe_or = 4'h0; oe_and = 4'hF;
        if (quad) begin
            for (int n = 1; n >= 0; n--) begin
                io_in = 4'h0;
                wait_clk(HALF);
                rx[n*4 +: 4] = io_out; oe_or |= io_oe; oe_and &= io_oe;
                sck = 1'b1; wait_clk(HALF); sck = 1'b0;
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                io_in = {3'b000, tx[i]};
                wait_clk(HALF);
                rx[i] = io_out[1]; oe_or |= io_oe; oe_and &= io_oe;
                sck = 1'b1; wait_clk(HALF); sck = 1'b0;
            end
        end
    endtask

    task automatic cs_begin();
        csn = 1'b0; wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF); csn = 1'b1; wait_clk(8);
    endtask

    task automatic cmd_addr(input logic [7:0] op, input logic [23:0] a);
        xfer(op, 1'b0); xfer(a[23:16], 1'b0); xfer(a[15:8], 1'b0); xfer(a[7:0], 1'b0);
    endtask

    task automatic simple_cmd(input logic [7:0] op);
        cs_begin(); xfer(op, 1'b0); cs_end();
    endtask

    task automatic rdsr();
        cs_begin(); xfer(8'h05, 1'b0); xfer(8'h00, 1'b0); cs_end();
    endtask

    task automatic read1(input logic [23:0] a);
        cs_begin(); cmd_addr(8'h03, a); xfer(8'h00, 1'b0); cs_end();
    endtask

    initial begin
        // reset state
        wait_clk(3);
        check_eq("rst_oe", {28'd0, io_oe}, 32'h0);
        check_eq("rst_out", {28'd0, io_out}, 32'h0);
        rst = 1'b1;
        wait_clk(3);
        rdsr(); check_eq("rst_sr", {24'd0, rx}, 32'h00);

        preload(16'h00FF, 8'hFF); preload(16'h0100, 8'hA5); preload(16'h0101, 8'h5A);
        preload(16'h0102, 8'hC3); preload(16'h0103, 8'h3C); preload(16'h01FE, 8'h3C);
        preload(16'h01FF, 8'hFF); preload(16'h1000, 8'h12); preload(16'h1234, 8'h34);
        preload(16'h1FFF, 8'h56); preload(16'h0FFF, 8'h78);

        // single-lane read across the 0xFF/0x100 boundary
        cs_begin(); cmd_addr(8'h03, 24'h0000FF);
        xfer(8'h00, 1'b0); check_eq("rd_b0", {24'd0, rx}, 32'hFF);
        xfer(8'h00, 1'b0); check_eq("rd_b1", {24'd0, rx}, 32'hA5);
        xfer(8'h00, 1'b0); check_eq("rd_b2", {24'd0, rx}, 32'h5A);
        xfer(8'h00, 1'b0); check_eq("rd_b3", {24'd0, rx}, 32'hC3);
        cs_end();

        // quad read with 8 dummy cycles
        cs_begin(); cmd_addr(8'h6B, 24'h000100);
        xfer(8'h00, 1'b0); check_eq("qr_dummy_oe", {28'd0, oe_or}, 32'h0);
        xfer(8'h00, 1'b1); check_eq("qr_b0", {24'd0, rx}, 32'hA5);
        check_eq("qr_oe", {28'd0, oe_and}, 32'hF);
        xfer(8'h00, 1'b1); check_eq("qr_b1", {24'd0, rx}, 32'h5A);
        wait_clk(HALF);
        check_eq("qr_oe_pre", {28'd0, io_oe}, 32'hF);
        csn = 1'b1; wait_clk(3);
        check_eq("qr_cs_oe", {28'd0, io_oe}, 32'h0);
        wait_clk(5);

        // program without write enable is ignored
        cs_begin(); cmd_addr(8'h02, 24'h0001FE); xfer(8'h00, 1'b0); cs_end();
        read1(24'h0001FE); check_eq("pp_nowel", {24'd0, rx}, 32'h3C);
        rdsr(); check_eq("pp_nowel_sr", {24'd0, rx}, 32'h00);

        // program with page wrap and AND semantics
        simple_cmd(8'h06);
        rdsr(); check_eq("wren_sr", {24'd0, rx}, 32'h02);
        cs_begin(); cmd_addr(8'h02, 24'h0001FE);
        xfer(8'hF0, 1'b0); xfer(8'h0F, 1'b0); xfer(8'h11, 1'b0);
        cs_end();
        rdsr(); check_eq("pp_busy_sr", {24'd0, rx}, 32'h03);
        wait_clk(500);
        rdsr(); check_eq("pp_done_sr", {24'd0, rx}, 32'h00);
        read1(24'h0001FE); check_eq("pp_1fe", {24'd0, rx}, 32'h30);
        read1(24'h0001FF); check_eq("pp_1ff", {24'd0, rx}, 32'h0F);
        read1(24'h000100); check_eq("pp_100", {24'd0, rx}, 32'h01);

        // sector erase
        simple_cmd(8'h06);
        cs_begin(); cmd_addr(8'h20, 24'h001234); cs_end();
        rdsr(); check_eq("se_busy_sr", {24'd0, rx}, 32'h03);
        read1(24'h001000);
        check_eq("se_rd_oe", {28'd0, oe_or}, 32'h0);
        check_eq("se_rd_data", {24'd0, rx}, 32'h00);
        wait_clk(4200);
        rdsr(); check_eq("se_done_sr", {24'd0, rx}, 32'h00);
        read1(24'h001000); check_eq("se_1000", {24'd0, rx}, 32'hFF);
        read1(24'h001234); check_eq("se_1234", {24'd0, rx}, 32'hFF);
        read1(24'h001FFF); check_eq("se_1fff", {24'd0, rx}, 32'hFF);
        read1(24'h000FFF); check_eq("se_0fff", {24'd0, rx}, 32'h78);

        // JEDEC ID then 0xFF padding
        cs_begin(); xfer(8'h9F, 1'b0);
        xfer(8'h00, 1'b0); check_eq("id_b0", {24'd0, rx}, 32'h01);
        xfer(8'h00, 1'b0); check_eq("id_b1", {24'd0, rx}, 32'h02);
        xfer(8'h00, 1'b0); check_eq("id_b2", {24'd0, rx}, 32'h20);
        xfer(8'h00, 1'b0); check_eq("id_b3", {24'd0, rx}, 32'hFF);
        cs_end();

        // partial data byte is dropped and WEL survives
        simple_cmd(8'h06);
        cs_begin(); cmd_addr(8'h02, 24'h000103);
        for (int b = 0; b < 4; b++) begin
            io_in = 4'h0; wait_clk(HALF);
            sck = 1'b1; wait_clk(HALF); sck = 1'b0;
        end
        cs_end();
        rdsr(); check_eq("pp_part_sr", {24'd0, rx}, 32'h02);
        read1(24'h000103); check_eq("pp_part_mem", {24'd0, rx}, 32'h3C);

        // reset in the middle of a read
        cs_begin(); cmd_addr(8'h03, 24'h000100);
        xfer(8'h00, 1'b0); check_eq("mid_rd", {24'd0, rx}, 32'h01);
        wait_clk(HALF);
        check_eq("mid_oe", {28'd0, io_oe}, 32'h2);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_oe", {28'd0, io_oe}, 32'h0);
        check_eq("mid_rst_out", {28'd0, io_out}, 32'h0);
        csn = 1'b1; sck = 1'b0;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(6);
        rdsr(); check_eq("mid_rst_sr", {24'd0, rx}, 32'h00);
        read1(24'h000102); check_eq("post_rst_rd", {24'd0, rx}, 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
